// File: rtl/fpr_cdb_arbiter_if.sv
// Request/grant and broadcast signals between the FP execution units and the
// FPR common data bus arbiter.
interface fpr_cdb_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int ROB_WIDTH = 5
);
    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [DATA_W-1:0]    data;
    } cdb_t;

    logic [N_REQ-1:0]                req_valid;
    logic [N_REQ-1:0][ROB_WIDTH-1:0] req_tag;
    logic [N_REQ-1:0][DATA_W-1:0]    req_data;
    logic [N_REQ-1:0]                req_ready;
    cdb_t                            fpr_cdb;

    modport master (
        output req_valid, req_tag, req_data,
        input  req_ready, fpr_cdb
    );

    modport slave (
        input  req_valid, req_tag, req_data,
        output req_ready, fpr_cdb
    );
endinterface

// File: rtl/fpr_cdb_arbiter.sv
// Round-robin arbiter for the FPR common data bus: grant in cycle t, broadcast in t+1.
// Optional performance counters are built when FPR_CDB_PERF_EN is defined.
module fpr_cdb_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int ROB_WIDTH = 5
) (
    input  logic clk,
    input  logic reset,
    fpr_cdb_arbiter_if.slave bus
`ifdef FPR_CDB_PERF_EN
    ,
    output logic [31:0]            perf_busy,
    output logic [31:0]            perf_conflict,
    output logic [N_REQ-1:0][15:0] perf_wait
`endif
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     gnt;
    logic [PTR_W-1:0]     ptr_nxt;
    logic [PTR_W:0]       sum;
    logic [PTR_W-1:0]     idx;
    logic                 found;
    logic [N_REQ-1:0]     req_ready;

    logic [PTR_W-1:0]     gnt_idx_p1;
    logic                 vld_p1;
    logic [ROB_WIDTH-1:0] tag_p1;

    // Stage p0: rotating priority search starting at ptr
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N_REQ)) begin
                sum = sum - (PTR_W+1)'(N_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (reset && found) begin
            req_ready[gnt] = 1'b1;
        end
    end

    assign bus.req_ready = req_ready;
    assign ptr_nxt = (gnt == PTR_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;

    // Stage p1: winner's tag and index registered; data is muxed live from the unit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr        <= '0;
            gnt_idx_p1 <= '0;
            vld_p1     <= 1'b0;
            tag_p1     <= '0;
        end else if (found) begin
            ptr        <= ptr_nxt;
            gnt_idx_p1 <= gnt;
            vld_p1     <= 1'b1;
            tag_p1     <= bus.req_tag[gnt];
        end else begin
            vld_p1     <= 1'b0;
        end
    end

    assign bus.fpr_cdb = {vld_p1, tag_p1, bus.req_data[gnt_idx_p1]};

`ifdef FPR_CDB_PERF_EN
    // Observation only: nothing here feeds back into the grant path
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_busy     <= '0;
            perf_conflict <= '0;
            perf_wait     <= '0;
        end else begin
            if (vld_p1) begin
                perf_busy <= perf_busy + 32'd1;
            end
            if ($countones(bus.req_valid) > 1) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_valid[i] && !req_ready[i] && perf_wait[i] != 16'hFFFF) begin
                    perf_wait[i] <= perf_wait[i] + 16'd1;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
// Bench for fpr_cdb_arbiter: vector table, directed corner sequences and
// randomized traffic against a rotating-distance priority model.
module tb_fpr_cdb_arbiter;
    localparam int N_REQ     = 4;
    localparam int DATA_W    = 32;
    localparam int ROB_WIDTH = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    fpr_cdb_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ROB_WIDTH(ROB_WIDTH)) bus();

`ifdef FPR_CDB_PERF_EN
    logic [31:0]            perf_busy;
    logic [31:0]            perf_conflict;
    logic [N_REQ-1:0][15:0] perf_wait;
`endif

    fpr_cdb_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ROB_WIDTH(ROB_WIDTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus)
`ifdef FPR_CDB_PERF_EN
        ,
        .perf_busy     (perf_busy),
        .perf_conflict (perf_conflict),
        .perf_wait     (perf_wait)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: next-priority unit, last winner, and the bus register contents
    int                   m_ptr;
    int                   m_idx;
    logic                 m_v;
    logic [ROB_WIDTH-1:0] m_tag;

    typedef struct {
        logic [N_REQ-1:0]     v;
        logic [N_REQ-1:0]     rdy;
        logic                 cv;
        logic [ROB_WIDTH-1:0] ctag;
        int                   didx;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Winner = requester with the smallest forward distance from the priority pointer
    function automatic int m_winner(input logic [N_REQ-1:0] v, input int p);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) begin
                d = (i - p + N_REQ) % N_REQ;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_idx = 0;
        m_v   = 1'b0;
        m_tag = '0;
    endtask

    task automatic model_chk(input string name);
        int w;
        logic [N_REQ-1:0] e;
        w = m_winner(bus.req_valid, m_ptr);
        e = '0;
        if (w >= 0) e[w] = 1'b1;
        chk({name, "_ready"}, 64'(bus.req_ready), 64'(e));
        chk({name, "_valid"}, 64'(bus.fpr_cdb.valid), 64'(m_v));
        chk({name, "_tag"},   64'(bus.fpr_cdb.tag), 64'(m_tag));
        chk({name, "_data"},  64'(bus.fpr_cdb.data), 64'(bus.req_data[m_idx]));
    endtask

    task automatic step();
        int w;
        w = m_winner(bus.req_valid, m_ptr);
        if (w >= 0) begin
            m_ptr = (w + 1) % N_REQ;
            m_idx = w;
            m_v   = 1'b1;
            m_tag = bus.req_tag[w];
        end else begin
            m_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        bus.req_valid = '0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic set_fixed_payload();
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_tag[i]  = ROB_WIDTH'(20 + i);
            bus.req_data[i] = 32'h1000_0000 + 32'(i);
        end
    endtask

    initial begin
        tbl[0]  = '{4'hF, 4'h1, 1'b0, 5'd0,  0};
        tbl[1]  = '{4'hF, 4'h2, 1'b1, 5'd20, 0};
        tbl[2]  = '{4'hF, 4'h4, 1'b1, 5'd21, 1};
        tbl[3]  = '{4'hF, 4'h8, 1'b1, 5'd22, 2};
        tbl[4]  = '{4'hF, 4'h1, 1'b1, 5'd23, 3};
        tbl[5]  = '{4'hF, 4'h2, 1'b1, 5'd20, 0};
        tbl[6]  = '{4'hF, 4'h4, 1'b1, 5'd21, 1};
        tbl[7]  = '{4'hF, 4'h8, 1'b1, 5'd22, 2};
        tbl[8]  = '{4'hA, 4'h2, 1'b1, 5'd23, 3};
        tbl[9]  = '{4'hA, 4'h8, 1'b1, 5'd21, 1};
        tbl[10] = '{4'h0, 4'h0, 1'b1, 5'd23, 3};
        tbl[11] = '{4'h1, 4'h1, 1'b0, 5'd23, 3};
        tbl[12] = '{4'h0, 4'h0, 1'b1, 5'd20, 0};

        // Reset held: requests present but no grant and an idle bus
        bus.req_valid = '1;
        set_fixed_payload();
        model_reset();
        #1;
        chk("rst_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_valid", 64'(bus.fpr_cdb.valid), 64'h0);
        chk("rst_tag",   64'(bus.fpr_cdb.tag), 64'h0);
        reset_dut();

        // Single request: grant now, broadcast next cycle, idle after
        bus.req_tag[0]  = 5'd5;
        bus.req_data[0] = 32'h3F80_0000;
        bus.req_valid   = 4'b0001;
        #1;
        chk("single_ready", 64'(bus.req_ready), 64'h1);
        step();
        bus.req_valid = '0;
        #1;
        chk("single_valid", 64'(bus.fpr_cdb.valid), 64'h1);
        chk("single_tag",   64'(bus.fpr_cdb.tag), 64'h5);
        chk("single_data",  64'(bus.fpr_cdb.data), 64'h3F80_0000);
        step();
        chk("single_idle",  64'(bus.fpr_cdb.valid), 64'h0);

        // Vector table: full rotation, wrap, skip pattern 1010, pointer back at 0
        reset_dut();
        set_fixed_payload();
        for (int i = 0; i < 13; i++) begin
            bus.req_valid = tbl[i].v;
            #1;
            chk($sformatf("tbl%0d_ready", i), 64'(bus.req_ready), 64'(tbl[i].rdy));
            chk($sformatf("tbl%0d_valid", i), 64'(bus.fpr_cdb.valid), 64'(tbl[i].cv));
            chk($sformatf("tbl%0d_tag", i),   64'(bus.fpr_cdb.tag), 64'(tbl[i].ctag));
            chk($sformatf("tbl%0d_data", i),  64'(bus.fpr_cdb.data), 64'h1000_0000 + 64'(tbl[i].didx));
            step();
        end

        // Lone requester granted back to back, bus never drops
        reset_dut();
        set_fixed_payload();
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 4'b0100;
            #1;
            chk($sformatf("lone%0d_ready", i), 64'(bus.req_ready), 64'h4);
            if (i > 0) chk($sformatf("lone%0d_valid", i), 64'(bus.fpr_cdb.valid), 64'h1);
            step();
        end
        bus.req_valid = '0;
        #1;
        chk("lone_last_valid", 64'(bus.fpr_cdb.valid), 64'h1);
        chk("lone_last_tag",   64'(bus.fpr_cdb.tag), 64'd22);

        // Asynchronous reset mid-stream with a broadcast in flight
        bus.req_valid = 4'b0100;
        step();
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", 64'(bus.fpr_cdb.valid), 64'h0);
        chk("arst_ready", 64'(bus.req_ready), 64'h0);
        chk("arst_tag",   64'(bus.fpr_cdb.tag), 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.req_valid = 4'b0010;
        #1;
        chk("arst_first_ready", 64'(bus.req_ready), 64'h2);
        step();
        bus.req_valid = '0;
        #1;
        chk("arst_first_valid", 64'(bus.fpr_cdb.valid), 64'h1);
        chk("arst_first_tag",   64'(bus.fpr_cdb.tag), 64'd21);

        // Randomized traffic against the model
        reset_dut();
        for (int c = 0; c < 300; c++) begin
            bus.req_valid = ($urandom_range(0, 7) == 0) ? '0 : N_REQ'($urandom);
            for (int i = 0; i < N_REQ; i++) begin
                bus.req_tag[i]  = ROB_WIDTH'($urandom);
                bus.req_data[i] = $urandom;
            end
            #1;
            model_chk($sformatf("rnd%0d", c));
            step();
        end

`ifdef FPR_CDB_PERF_EN
        // Four requesters, each leaving after its grant
        reset_dut();
        set_fixed_payload();
        bus.req_valid = 4'b1111; step();
        bus.req_valid = 4'b1110; step();
        bus.req_valid = 4'b1100; step();
        bus.req_valid = 4'b1000; step();
        bus.req_valid = 4'b0000; step();
        chk("perf_busy",     64'(perf_busy), 64'd4);
        chk("perf_conflict", 64'(perf_conflict), 64'd3);
        for (int i = 0; i < N_REQ; i++) begin
            chk($sformatf("perf_wait%0d", i), 64'(perf_wait[i]), 64'(i));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fpr_cdb_arbiter.md
Name: fpr_cdb_arbiter

Overview:
- Shares the single FPR common data bus (fpr_cdb) among the FP execution units: fmov, fadd, fmul, fdiv/fsqrt, load-FP, and so on.
- Each unit asserts a request with its ROB tag in cycle t. The arbiter grants exactly one unit per cycle, round-robin.
- The granted unit latches its result at the grant edge. In cycle t+1 the arbiter broadcasts valid/tag/data on fpr_cdb.
- fpr_cdb feeds the reservation stations, the ROB and the fpr_read bypass.

Parameters:
- N_REQ, 4, number of requesting units (2..8).
- DATA_W, 32, result width.

Ports:
- clk  in  1  clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  [N_REQ-1:0]  unit i has a dispatchable result (its fpr_cdb_req.valid).
- req_tag  in  [N_REQ-1:0][ROB_WIDTH-1:0]  ROB tag of unit i's result; valid with req_valid.
- req_data  in  [N_REQ-1:0][DATA_W-1:0]  unit i's registered result; sampled in the cycle after its grant.
- req_ready  out  [N_REQ-1:0]  grant, one-hot or zero; combinational from req_valid and the round-robin pointer.
- fpr_cdb  out  cdb_t  broadcast bus with fields valid, tag[ROB_WIDTH-1:0], data[31:0].

Behaviour:
- Grant (combinational, cycle t):
  - Search req_valid starting at index ptr, ascending with wrap mod N_REQ. The first set bit is the winner g.
  - req_ready = one-hot(g) if any req_valid, else 0.
  - A unit treats req_valid&&req_ready at the edge as dispatch.
- Registered state, updated at posedge when a grant exists:
  - ptr <= (g+1) mod N_REQ.
  - gnt_idx <= g.
  - cdb_v <= 1.
  - cdb_tag <= req_tag[g].
- With no grant: cdb_v <= 0; ptr, gnt_idx and cdb_tag hold.
- Output (cycle t+1):
  - fpr_cdb.valid = cdb_v.
  - fpr_cdb.tag = cdb_tag.
  - fpr_cdb.data = req_data[gnt_idx], combinational mux.
  - Latency: request cycle to bus cycle = exactly 1.
- No backpressure from the bus: fpr_cdb is always accepted.
- Throughput: 1 broadcast per cycle.
- Fairness: a continuously requesting unit is granted within N_REQ cycles.
- Boundary conditions:
  - All N_REQ requesting every cycle: grants rotate 0,1,...,N_REQ-1,0,...
  - Single requester: granted every cycle back to back; ptr moves past it each time, which is harmless.
  - ptr = N_REQ-1 with a grant: ptr wraps to 0.
  - A requester that drops req_valid before grant is simply skipped. There is no requirement on request stability.
  - req_tag is never inspected. Duplicate tags are a caller error, passed through unchanged.
- Reset (reset=0, asynchronous):
  - Immediately: ptr=0, gnt_idx=0, cdb_v=0, cdb_tag=0, so fpr_cdb.valid=0 in the same cycle.
  - req_ready is forced to 0 while reset is low.
  - A grant issued in the cycle that reset asserts is discarded; units are reset by the same signal.
  - Reset deassertion is synchronised externally. The first grant is possible on the first edge after release.
- No state machine beyond ptr/gnt_idx/cdb_v; no X is driven onto fpr_cdb.valid at any time.

Optional Feature:
- Macro: FPR_CDB_PERF_EN.
- When defined, add output ports:
  - perf_busy  32  cycles with fpr_cdb.valid=1.
  - perf_conflict  32  cycles where more than one req_valid was set.
  - perf_wait  [N_REQ-1:0][15:0]  saturating count of cycles unit i requested without grant.
- All counters reset to 0, wrap (busy/conflict) or saturate at 16'hFFFF (wait). Counters never affect grant behaviour.
- When not defined, these ports and the counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then req_valid=4'b0001, tag 5, unit0 data 32'h3F800000:
  - req_ready=0001 in the same cycle.
  - Next cycle fpr_cdb = {1, 5, 32'h3F800000}.
  - The cycle after, valid=0.
- req_valid=4'b1111 held for 8 cycles from ptr=0 -> grants 0,1,2,3,0,1,2,3; fpr_cdb.tag follows the matching tags one cycle later; no gaps.
- Grant to unit 3 (ptr -> 0), then req_valid=4'b1010 -> unit 1 granted, then unit 3; ptr ends at 0.
- req_valid=4'b0100 every cycle for 5 cycles -> 5 consecutive broadcasts, valid never drops.
- reset low mid-stream with a grant pending -> fpr_cdb.valid and req_ready=0 immediately without a clock. After release, req_valid=4'b0010 -> unit 1 granted first (ptr=0).
- With FPR_CDB_PERF_EN, 4 requesters for 4 cycles -> perf_busy=4 after the last broadcast, perf_conflict=3, perf_wait={3,2,1,0} for units 3..0.
